// File: rtl/power2round_skbuff.sv
// Bit-packing elastic buffer between the power2round datapath and the secret-key
// memory write port: accepts IN_W-bit chunks and emits OUT_W-bit words LSB-first.
module power2round_skbuff #(
  parameter int unsigned IN_W  = 104,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned BUF_W = 208,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             zeroize,
  input  logic [IN_W-1:0]  data_i,
  input  logic             valid_i,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] BUF_C = CNT_W'(BUF_W);
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(BUF_W - IN_W);

  logic [BUF_W-1:0] buf_q, buf_d, post_drain, append;
  logic [CNT_W-1:0] cnt_q, cnt_d, drained;
  logic             accept;

  always_comb begin
    valid_o = (cnt_q >= OUT_C);
    data_o  = buf_q[OUT_W-1:0];
    cnt_o   = cnt_q;
    drained = cnt_q - (valid_o ? OUT_C : '0);
    full_o  = (drained > LIM_C);
    accept  = valid_i & ~full_o;
  end

  // Drain happens first; the new chunk lands right above the bits that survive it.
  always_comb begin
    post_drain = valid_o ? (buf_q >> OUT_W) : buf_q;
    append     = BUF_W'(data_i) << drained;
    buf_d      = post_drain;
    cnt_d      = drained;
    if (accept) begin
      buf_d = post_drain | append;
      cnt_d = drained + IN_C;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (zeroize) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
    cnt_q <= BUF_C);

  a_upper_clean: assert property (@(posedge clk) disable iff (!reset_n)
    (buf_q >> cnt_q) == '0);

  // A chunk rejected on full must be re-presented unchanged if valid stays high.
  a_represent: assert property (@(posedge clk) disable iff (!reset_n)
    (valid_i && full_o && !zeroize) |=> (!valid_i || $stable(data_i)));

endmodule

// File: tb/tb_power2round_skbuff.sv
// Directed self-checking bench for power2round_skbuff.
module tb_power2round_skbuff;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         zeroize;
  logic [103:0] data_i;
  logic         valid_i;
  logic [63:0]  data_o;
  logic         valid_o;
  logic         full_o;
  logic [7:0]   cnt_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [103:0] chunks [32];

  power2round_skbuff #(.IN_W(104), .OUT_W(64), .BUF_W(208), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .data_i(data_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .full_o(full_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [103:0] mk(input int unsigned base);
    logic [103:0] r;
    for (int j = 0; j < 8; j++) r[13*j +: 13] = 13'(base + j);
    return r;
  endfunction

  function automatic logic [63:0] ref_word(input int unsigned w);
    logic [63:0] r;
    for (int b = 0; b < 64; b++) begin
      int unsigned idx;
      idx = 64 * w + b;
      r[b] = chunks[idx / 104][idx % 104];
    end
    return r;
  endfunction

  task automatic do_zeroize();
    @(negedge clk);
    valid_i = 1'b0;
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++; if (cnt_o !== 8'd0) $display("FAIL reset_cnt: got %0d exp 0", cnt_o); else pass_cnt++;
    total_cnt++; if (valid_o !== 1'b0 || full_o !== 1'b0) $display("FAIL reset_flags: got v=%b f=%b exp 0 0", valid_o, full_o); else pass_cnt++;
    total_cnt++; if (data_o !== 64'h0) $display("FAIL reset_data: got %h exp 0", data_o); else pass_cnt++;
    @(negedge clk); valid_i = 1'b1; data_i = mk(800);
    @(negedge clk); data_i = mk(900);
    @(negedge clk); valid_i = 1'b0;
    total_cnt++; if (cnt_o !== 8'd144) $display("FAIL midrst_pre_cnt: got %0d exp 144", cnt_o); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (cnt_o !== 8'd0 || valid_o !== 1'b0 || full_o !== 1'b0 || data_o !== 64'h0)
      $display("FAIL midrst_async: got cnt=%0d v=%b f=%b d=%h exp all 0", cnt_o, valid_o, full_o, data_o);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (cnt_o !== 8'd0 || data_o !== 64'h0)
      $display("FAIL midrst_after: got cnt=%0d d=%h exp 0 0", cnt_o, data_o);
    else pass_cnt++;
  endtask

  task automatic test_single();
    @(negedge clk); valid_i = 1'b1; data_i = {104{1'b1}};
    @(negedge clk); valid_i = 1'b0;
    total_cnt++; if (valid_o !== 1'b1 || data_o !== 64'hFFFF_FFFF_FFFF_FFFF || cnt_o !== 8'd104)
      $display("FAIL single_first: got v=%b d=%h cnt=%0d exp 1 ffffffffffffffff 104", valid_o, data_o, cnt_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (valid_o !== 1'b0 || cnt_o !== 8'd40 || data_o !== 64'h0000_00FF_FFFF_FFFF || full_o !== 1'b0)
      $display("FAIL single_second: got v=%b cnt=%0d d=%h f=%b exp 0 40 000000ffffffffff 0", valid_o, cnt_o, data_o, full_o);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (valid_o !== 1'b0 || cnt_o !== 8'd40)
      $display("FAIL single_idle: got v=%b cnt=%0d exp 0 40", valid_o, cnt_o);
    else pass_cnt++;
    do_zeroize();
    total_cnt++; if (cnt_o !== 8'd0 || data_o !== 64'h0)
      $display("FAIL single_zeroize: got cnt=%0d d=%h exp 0 0", cnt_o, data_o);
    else pass_cnt++;
  endtask

  task automatic test_ordering();
    logic [7:0]  exp_cnt [16] = '{8'd0, 8'd104, 8'd144, 8'd184, 8'd120, 8'd160, 8'd200, 8'd136,
                                  8'd176, 8'd112, 8'd152, 8'd192, 8'd128, 8'd64, 8'd0, 8'd0};
    logic [15:0] exp_full = 16'b0000_1001_0100_1000; // bit i = cycle i
    int unsigned k = 0;
    int unsigned w = 0;
    for (int c = 0; c < 8; c++) chunks[c] = mk(8 * c + 1);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      total_cnt++; if (cnt_o !== exp_cnt[cyc]) $display("FAIL order_cnt[%0d]: got %0d exp %0d", cyc, cnt_o, exp_cnt[cyc]); else pass_cnt++;
      total_cnt++; if (full_o !== exp_full[cyc]) $display("FAIL order_full[%0d]: got %b exp %b", cyc, full_o, exp_full[cyc]); else pass_cnt++;
      if (valid_o) begin
        total_cnt++; if (data_o !== ref_word(w)) $display("FAIL order_word[%0d]: got %h exp %h", w, data_o, ref_word(w)); else pass_cnt++;
        w++;
      end
      valid_i = (k < 8);
      data_i  = (k < 8) ? chunks[k] : '0;
      if (valid_i && !full_o) k++;
    end
    valid_i = 1'b0;
    total_cnt++; if (w != 13 || k != 8) $display("FAIL order_counts: got words=%0d chunks=%0d exp 13 8", w, k); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int unsigned k = 0;
    int unsigned w = 0;
    int unsigned cyc = 0;
    for (int c = 0; c < 32; c++) chunks[c] = mk((37 * c + 5) % 8000);
    while (!(k == 32 && cnt_o == 8'd0) && cyc < 200) begin
      @(negedge clk);
      if (valid_o) begin
        if (w < 52) begin
          total_cnt++; if (data_o !== ref_word(w)) $display("FAIL bp_word[%0d]: got %h exp %h", w, data_o, ref_word(w)); else pass_cnt++;
        end
        w++;
      end
      valid_i = (k < 32);
      data_i  = (k < 32) ? chunks[k] : '0;
      if (valid_i && !full_o) k++;
      cyc++;
    end
    valid_i = 1'b0;
    total_cnt++; if (cyc >= 200) $display("FAIL bp_timeout: got %0d cycles exp < 200", cyc); else pass_cnt++;
    total_cnt++; if (k != 32 || w != 52) $display("FAIL bp_counts: got chunks=%0d words=%0d exp 32 52", k, w); else pass_cnt++;
    total_cnt++; if (cnt_o !== 8'd0) $display("FAIL bp_final_cnt: got %0d exp 0", cnt_o); else pass_cnt++;
  endtask

  task automatic test_zeroize();
    logic [103:0] x;
    x = mk(400);
    @(negedge clk); valid_i = 1'b1; data_i = mk(100);
    @(negedge clk); data_i = mk(200);
    @(negedge clk);
    total_cnt++; if (cnt_o !== 8'd144) $display("FAIL zero_pre_cnt: got %0d exp 144", cnt_o); else pass_cnt++;
    zeroize = 1'b1; data_i = mk(300);
    @(negedge clk);
    zeroize = 1'b0;
    total_cnt++; if (cnt_o !== 8'd0 || valid_o !== 1'b0 || data_o !== 64'h0)
      $display("FAIL zero_clear: got cnt=%0d v=%b d=%h exp 0 0 0", cnt_o, valid_o, data_o);
    else pass_cnt++;
    data_i = x;
    @(negedge clk); valid_i = 1'b0;
    total_cnt++; if (cnt_o !== 8'd104 || valid_o !== 1'b1 || data_o !== x[63:0])
      $display("FAIL zero_restart: got cnt=%0d v=%b d=%h exp 104 1 %h", cnt_o, valid_o, data_o, x[63:0]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (cnt_o !== 8'd40 || data_o !== {24'h0, x[103:64]})
      $display("FAIL zero_tail: got cnt=%0d d=%h exp 40 %h", cnt_o, data_o, {24'h0, x[103:64]});
    else pass_cnt++;
    do_zeroize();
  endtask

  task automatic test_ignore_on_full();
    logic [311:0] r;
    logic [103:0] p;
    r = {mk(700), mk(600), mk(500)};
    p = {13{8'hA5}};
    @(negedge clk); valid_i = 1'b1; data_i = mk(500);
    @(negedge clk); data_i = mk(600);
    @(negedge clk); data_i = mk(700);
    @(negedge clk);
    total_cnt++; if (cnt_o !== 8'd184 || full_o !== 1'b1 || data_o !== r[191:128])
      $display("FAIL ign_full_state: got cnt=%0d f=%b d=%h exp 184 1 %h", cnt_o, full_o, data_o, r[191:128]);
    else pass_cnt++;
    data_i = p;
    @(negedge clk); valid_i = 1'b0; data_i = '0;
    total_cnt++; if (cnt_o !== 8'd120 || data_o !== r[255:192])
      $display("FAIL ign_drain1: got cnt=%0d d=%h exp 120 %h", cnt_o, data_o, r[255:192]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (cnt_o !== 8'd56 || valid_o !== 1'b0 || data_o !== {8'h0, r[311:256]})
      $display("FAIL ign_drain2: got cnt=%0d v=%b d=%h exp 56 0 %h", cnt_o, valid_o, data_o, {8'h0, r[311:256]});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (cnt_o !== 8'd56 || data_o !== {8'h0, r[311:256]})
      $display("FAIL ign_hold: got cnt=%0d d=%h exp 56 %h", cnt_o, data_o, {8'h0, r[311:256]});
    else pass_cnt++;
    do_zeroize();
  endtask

  initial begin
    reset_n = 1'b0;
    zeroize = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_ordering();
    test_backpressure();
    test_zeroize();
    test_ignore_on_full();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
